seq_detect_1011: RTL

SEQ_DETECT_1011 -- requirements
Module: seq_detect_1011

---
 rtl/seq_pkg.sv | 15 +
 rtl/sat_counter.sv | 36 +++
 rtl/seq_detect_1011.sv | 71 +++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the 1011 serial pattern detector: state encodings and pattern constant.
package seq_pkg;

    localparam int unsigned STATE_W = 3;
    localparam logic [3:0]  PATTERN = 4'b1011;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 3'd0,
        S_1    = 3'd1,
        S_10   = 3'd2,
        S_101  = 3'd3,
        S_1011 = 3'd4
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] q_q;
    logic [CNT_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != CNT_MAX)) begin
            q_d = q_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/seq_detect_1011.sv
// Moore FSM detecting the serial pattern 1011 on qualified input bits, with a
// registered match pulse and a saturating match counter.
module seq_detect_1011
    import seq_pkg::*;
#(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned OVERLAP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din_valid,
    input  logic             din,
    input  logic             clr_cnt,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic [2:0]       state_o
);

    state_e state_q;
    state_e state_d;
    logic   match_q;
    logic   match_d;

    // Next-state: each accepted bit advances along the 1011 prefix chain.
    always_comb begin
        state_d = state_q;
        match_d = 1'b0;
        unique case (state_q)
            S_IDLE: if (din_valid) state_d = (din == PATTERN[3]) ? S_1 : S_IDLE;
            S_1:    if (din_valid) state_d = (din == PATTERN[2]) ? S_10 : S_1;
            S_10:   if (din_valid) state_d = (din == PATTERN[1]) ? S_101 : S_IDLE;
            S_101:  if (din_valid) state_d = (din == PATTERN[0]) ? S_1011 : S_10;
            S_1011: begin
                if (din_valid) begin
                    if (din) begin
                        state_d = S_1;
                    end else begin
                        state_d = (OVERLAP != 0) ? S_10 : S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // S_1011 has no self-loop, so this pulses only on entry.
        match_d = din_valid && (state_d == S_1011);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (match_d),
        .clr   (clr_cnt),
        .q     (match_cnt)
    );

    assign match   = match_q;
    assign state_o = 3'(state_q);

endmodule
